dmem_arbiter: RTL
=================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port DataMemory between two requesters: port 0 (CPU load/store
//  unit) and port 1 (loader/DMA that fills or dumps memory). Arbitrates, latches one
//  command, drives the memory for one cycle and returns read data with a valid
//  pulse. Sits between the datapath/loader and DataMemory; DataMemory ports connect 1:1.
// PARAMETERS
//  ADDR_W  32  address width, word index, passed to memory unchanged
//  DATA_W  32  data width
//  FAIR    1   1 = round-robin on simultaneous requests; 0 = fixed priority, port 0 wins
// PORTS
//  clk             in   1       single clock, all state updates on posedge
//  rst             in   1       reset, synchronous, active-high
//  rN_req          in   1       N=0,1: command pending; hold with rN_we/addr/wdata until gnt
//  rN_we           in   1       1 = write, 0 = read
//  rN_addr         in   ADDR_W  word address
//  rN_wdata        in   DATA_W  write data
//  rN_gnt          out  1       one-cycle pulse: command latched this edge
//  rN_rvalid       out  1       one-cycle pulse: rN_rdata valid (reads only)
//  rN_rdata        out  DATA_W  read data, held until next read completes for port N
//  mem_read        out  1       to DataMemory mem_read
//  mem_write       out  1       to DataMemory mem_write
//  mem_address     out  ADDR_W  to DataMemory address
//  mem_write_data  out  DATA_W  to DataMemory write_data
//  mem_read_data   in   DATA_W  from DataMemory read_data, valid in the mem_read cycle
//  busy            out  1       1 while in ACCESS
// BEHAVIOUR
//  Reset: state=IDLE, last=1 (port 0 wins first tie), all gnt/rvalid/mem_read/mem_write=0,
//   mem_address/mem_write_data/rN_rdata=0.
//  FSM IDLE: if any req, pick winner; rN_gnt=1 this cycle (combinational); latch we/addr/wdata
//   and owner; -> ACCESS. No req: stay; memory strobes 0.
//  FSM ACCESS: exactly one cycle; mem_address/mem_write_data from latch; mem_write=we,
//   mem_read=~we; on read, capture mem_read_data into owner's rdata reg at the edge;
//   -> IDLE. rN_rvalid=1 in the following cycle (registered), may overlap next IDLE gnt.
//  Throughput: one access per 2 cycles; read latency gnt->rvalid = 2 cycles.
//  Arbitration: one req -> it wins. Both req: FAIR=1 -> the port != last; FAIR=0 -> port 0.
//   last updates only on a grant.
//  Loser keeps req high and is granted at the next IDLE (no starvation with FAIR=1).
//  Requests during ACCESS ignored (no gnt); gnt never in two consecutive cycles.
//  Requester may change/drop req only after gnt; drop before gnt = command withdrawn.
//  rst during ACCESS: mem_write and mem_read gated by ~rst combinationally -> write
//   suppressed; no rvalid issued; next cycle IDLE.
//  Write: rvalid never asserted; rdata unchanged.
// STRUCTURE
//  dmem_defs.vh: state encodings (S_IDLE=0, S_ACCESS=1), port ids (P_CPU=0, P_DMA=1).
//  Sub-module rr_arbiter2: req[1:0], last, FAIR -> one-hot gnt[1:0]; pure combinational.
//  Top: FSM, command latch, last pointer, per-port rdata/rvalid regs.
// TESTING (bench instantiates dmem_arbiter + DataMemory)
//  Reset: rst=1 two cycles -> all gnt/rvalid/mem strobes 0, busy=0.
//  Single read: r0 read addr 3 -> r0_gnt next edge, mem_read=1 one cycle with
//   mem_address=3, r0_rvalid 2 cycles after gnt, r0_rdata = memory word 3.
//  Write then read: r1 write addr 1 data 32'h12345678 -> gnt; then r1 read addr 1 ->
//   r1_rdata=32'h12345678, r1_rvalid one pulse, r0_rvalid stays 0.
//  Contention: both req every cycle, FAIR=1 -> grants 0,1,0,1 at 2-cycle spacing;
//   FAIR=0 -> port 0 only, port 1 granted once r0_req drops.
//  Reset mid-op: assert rst in ACCESS of write addr 2 data 32'hDEADBEEF -> mem_write=0
//   that cycle, addr 2 keeps reset value, no rvalid.
//  Withdrawal: r1_req high one cycle during ACCESS then low -> no r1_gnt, no memory access.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
//------------------------------------------------------------------------------
// Module : dmem_arbiter_pkg
// Brief  : Shared definitions for the DataMemory arbiter: FSM state encoding
//          and requester port identifiers.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package dmem_arbiter_pkg;

  // Arbiter FSM states
  typedef enum logic [0:0] {
    S_IDLE   = 1'b0,
    S_ACCESS = 1'b1
  } state_t;

  // Requester port identifiers
  localparam logic P_CPU = 1'b0;  // port 0: CPU load/store unit
  localparam logic P_DMA = 1'b1;  // port 1: loader / DMA

endpackage

`default_nettype wire

// File: rtl/dmem_arbiter_rr.sv
//------------------------------------------------------------------------------
// Module : dmem_arbiter_rr
// Brief  : Two-way combinational arbiter. Produces a one-hot grant from two
//          request lines. On a tie it either alternates against the last
//          granted port (FAIR != 0) or always favours port 0 (FAIR == 0).
// Ports  : req[1:0] in  - request per port
//          last     in  - port id of the most recent grant
//          gnt[1:0] out - one-hot grant (all zero when no request)
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter_rr
  import dmem_arbiter_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11: begin
        // Tie: with fairness the port that did not win last time goes next.
        if ((FAIR != 0) && (last == P_CPU)) gnt = 2'b10;
        else                                gnt = 2'b01;
      end
      default: gnt = 2'b00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/dmem_arbiter.sv
//------------------------------------------------------------------------------
// Module : dmem_arbiter
// Brief  : Shares a single-port DataMemory between the CPU (port 0) and the
//          loader/DMA (port 1). A command is granted and latched in IDLE,
//          driven onto the memory for exactly one ACCESS cycle, and read data
//          is returned with a one-cycle valid pulse the cycle after.
// Ports  : clk, rst (sync, active-high)
//          rN_req/we/addr/wdata in  - command from port N, held until rN_gnt
//          rN_gnt               out - command latched at this edge
//          rN_rvalid/rdata      out - read completion for port N
//          mem_*                    - 1:1 connection to DataMemory
//          busy                 out - high during the ACCESS cycle
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int FAIR   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              r0_req,
  input  logic              r0_we,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [DATA_W-1:0] r0_wdata,
  output logic              r0_gnt,
  output logic              r0_rvalid,
  output logic [DATA_W-1:0] r0_rdata,
  input  logic              r1_req,
  input  logic              r1_we,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [DATA_W-1:0] r1_wdata,
  output logic              r1_gnt,
  output logic              r1_rvalid,
  output logic [DATA_W-1:0] r1_rdata,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  input  logic [DATA_W-1:0] mem_read_data,
  output logic              busy
);

  state_t              state_q,  state_d;
  logic                last_q,   last_d;
  logic                owner_q,  owner_d;
  logic                we_q,     we_d;
  logic [ADDR_W-1:0]   addr_q,   addr_d;
  logic [DATA_W-1:0]   wdata_q,  wdata_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;

  logic [1:0]          arb_req;
  logic [1:0]          arb_gnt;

  // Requests are only considered in IDLE and never while reset is asserted,
  // so a grant can never appear in two consecutive cycles.
  assign arb_req = {r1_req, r0_req} & {2{(state_q == S_IDLE) && !rst}};

  dmem_arbiter_rr #(
    .FAIR (FAIR)
  ) u_rr (
    .req  (arb_req),
    .last (last_q),
    .gnt  (arb_gnt)
  );

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    owner_d   = owner_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata0_d  = rdata0_q;
    rdata1_d  = rdata1_q;
    rvalid0_d = 1'b0;
    rvalid1_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (arb_gnt != 2'b00) begin
          state_d = S_ACCESS;
          owner_d = arb_gnt[1] ? P_DMA : P_CPU;
          last_d  = arb_gnt[1] ? P_DMA : P_CPU;
          we_d    = arb_gnt[1] ? r1_we    : r0_we;
          addr_d  = arb_gnt[1] ? r1_addr  : r0_addr;
          wdata_d = arb_gnt[1] ? r1_wdata : r0_wdata;
        end
      end
      S_ACCESS: begin
        state_d = S_IDLE;
        // Memory read data is valid during this cycle; capture it for the owner.
        if (!we_q) begin
          if (owner_q == P_DMA) begin
            rdata1_d  = mem_read_data;
            rvalid1_d = 1'b1;
          end else begin
            rdata0_d  = mem_read_data;
            rvalid0_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      last_q    <= P_DMA;  // makes port 0 win the first tie
      owner_q   <= P_CPU;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata0_q  <= rdata0_d;
      rdata1_q  <= rdata1_d;
      rvalid0_q <= rvalid0_d;
      rvalid1_q <= rvalid1_d;
    end
  end

  assign r0_gnt    = arb_gnt[0];
  assign r1_gnt    = arb_gnt[1];
  assign r0_rvalid = rvalid0_q;
  assign r1_rvalid = rvalid1_q;
  assign r0_rdata  = rdata0_q;
  assign r1_rdata  = rdata1_q;

  // Strobes are gated by rst so a reset landing in ACCESS suppresses the write.
  assign mem_read       = (state_q == S_ACCESS) && !we_q && !rst;
  assign mem_write      = (state_q == S_ACCESS) &&  we_q && !rst;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;
  assign busy           = (state_q == S_ACCESS);

endmodule

`default_nettype wire
